// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
//   AXI4-Lite responder exposing NUM_REGS read/write configuration registers.
//   AW and W are accepted independently and in either order; the write commits
//   on the edge where the second of the two handshakes completes. Byte strobes
//   are honoured per register. Reads are answered from a single output register.
//   Out-of-range accesses get SLVERR (reads return zero data).
//
// Optional build macro: AXI_LITE_SLAVE_STATUS_EN
//   Adds sts_data_i; word indices [NUM_REGS, NUM_REGS+NUM_STS) read status
//   words with OKAY, and writes there get SLVERR.
//
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*          write address / data / response channels
//   S_AXI_AR*/R*             read address / data channels
//   cfg_data_o               register k at bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
//   wr_pulse_o               bit k high for one cycle when register k is written
//   sts_data_i               status words (macro builds only)

// One configuration register with byte-lane write enables.
module axi_lite_slave_regs_word #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [W-1:0]   wdata,
    input  logic [W/8-1:0] wstrb,
    output logic [W-1:0]   q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < W/8; b++) begin
                if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

module axi_lite_slave_regs #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_STS        = 4
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] cfg_data_o,
    output logic [NUM_REGS-1:0]                wr_pulse_o
`ifdef AXI_LITE_SLAVE_STATUS_EN
    ,
    input  logic [NUM_STS*AXI_DATA_WIDTH-1:0]  sts_data_i
`endif
);
    localparam int         STRB_W      = AXI_DATA_WIDTH / 8;
    localparam int         ADDR_LSB    = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Protection bits carry no meaning for this register bank.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    logic                      out_of_reset;
    logic                      aw_held, w_held;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;

    logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]       wr_hit, wr_en;

    // Readies are held low during the reset cycle and come up once reset is gone.
    assign S_AXI_AWREADY = out_of_reset && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = out_of_reset && !w_held  && !S_AXI_BVALID;
    assign S_AXI_ARREADY = out_of_reset && !S_AXI_RVALID;

    logic aw_hs, w_hs, ar_hs, commit;
    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Commit on the edge that completes the pair, taking whichever half
    // arrives this cycle straight from the bus and the other from its holder.
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_idx, ar_idx;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]         wr_strb;
    assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
    assign wr_idx  = wr_addr >> ADDR_LSB;
    assign ar_idx  = S_AXI_ARADDR >> ADDR_LSB;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        assign wr_hit[k] = (wr_idx == AXI_ADDR_WIDTH'(k));
        assign wr_en[k]  = commit && wr_hit[k];
        axi_lite_slave_regs_word #(.W(AXI_DATA_WIDTH)) u_word (
            .clk   (aclk),
            .rst   (areset),
            .we    (wr_en[k]),
            .wdata (wr_data),
            .wstrb (wr_strb),
            .q     (regs[k])
        );
    end

    assign cfg_data_o = regs;

    // Read lookup; anything not matched stays zero with SLVERR.
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic                      rd_err;
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == AXI_ADDR_WIDTH'(k)) begin
                rd_word = regs[k];
                rd_err  = 1'b0;
            end
        end
`ifdef AXI_LITE_SLAVE_STATUS_EN
        for (int s = 0; s < NUM_STS; s++) begin
            if (ar_idx == AXI_ADDR_WIDTH'(NUM_REGS + s)) begin
                rd_word = sts_data_i[s*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                rd_err  = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_of_reset <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            wr_pulse_o   <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
        end else begin
            out_of_reset <= 1'b1;
            wr_pulse_o   <= '0;

            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
                wr_pulse_o   <= wr_en;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end

            // Readies are low while BVALID is set, so no commit can collide here.
            if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;

            // Lookup sees register values from before this edge, so a read
            // racing a commit to the same register returns the old contents.
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_word;
                S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;
    localparam int NR = 16;
    localparam int NS = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NR*32-1:0] cfg;
    logic [NR-1:0]    pulse;
`ifdef AXI_LITE_SLAVE_STATUS_EN
    logic [NS*32-1:0] sts;
`endif

    always #5 aclk = ~aclk;

    axi_lite_slave_regs dut (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .cfg_data_o    (cfg),
        .wr_pulse_o    (pulse)
`ifdef AXI_LITE_SLAVE_STATUS_EN
        ,
        .sts_data_i    (sts)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] mreg [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: word index from byte address, registers below NR, status above.
    task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(addr >> 2);
        d = '0;
        r = 2'b10;
        if (idx < NR) begin
            d = mreg[idx];
            r = 2'b00;
        end
`ifdef AXI_LITE_SLAVE_STATUS_EN
        else if (idx < NR + NS) begin
            d = sts[(idx-NR)*32 +: 32];
            r = 2'b00;
        end
`endif
    endtask

    task automatic chk_cfg(input string tag);
        for (int k = 0; k < NR; k++)
            chk($sformatf("%s_reg%0d", tag, k), cfg[k*32 +: 32], mreg[k]);
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0:       return awready;
            1:       return wready;
            2:       return awready && wready;
            default: return arready;
        endcase
    endfunction

    task automatic wait_rdy(input int w, input string tag);
        int n;
        n = 0;
        while (!rdy(w) && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        chk({tag, "_ready"}, rdy(w), 1'b1);
    endtask

    // mode 0: AW+W together; 1: W first then AW after gap; 2: AW first then W.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int mode, input int gap, input int hold);
        int idx;
        logic [1:0]  er;
        logic [15:0] ep;
        idx = int'(addr >> 2);
        er  = (idx < NR) ? 2'b00 : 2'b10;
        ep  = (idx < NR) ? (16'd1 << idx) : 16'd0;
        if (mode == 0) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
            wait_rdy(2, "aww");
            @(posedge aclk); #1;
            awvalid = 0; wvalid = 0;
        end else if (mode == 1) begin
            wdata = data; wstrb = strb; wvalid = 1;
            wait_rdy(1, "w");
            @(posedge aclk); #1;
            wvalid = 0;
            for (int i = 0; i < gap; i++) begin
                chk("wready_held", wready, 1'b0);
                chk("no_early_b", bvalid, 1'b0);
                @(posedge aclk); #1;
            end
            awaddr = addr; awvalid = 1;
            wait_rdy(0, "aw");
            @(posedge aclk); #1;
            awvalid = 0;
        end else begin
            awaddr = addr; awvalid = 1;
            wait_rdy(0, "aw");
            @(posedge aclk); #1;
            awvalid = 0;
            for (int i = 0; i < gap; i++) begin
                chk("awready_held", awready, 1'b0);
                chk("no_early_b", bvalid, 1'b0);
                @(posedge aclk); #1;
            end
            wdata = data; wstrb = strb; wvalid = 1;
            wait_rdy(1, "w");
            @(posedge aclk); #1;
            wvalid = 0;
        end
        if (idx < NR)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mreg[idx][b*8 +: 8] = data[b*8 +: 8];
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, er);
        chk("wr_pulse", pulse, ep);
        chk_cfg("wr");
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, er);
            chk("awready_blk", awready, 1'b0);
            chk("wready_blk", wready, 1'b0);
        end
        bready = 1;
        @(posedge aclk); #1;
        bready = 0;
        chk("bvalid_clr", bvalid, 1'b0);
        chk("pulse_clr", pulse, 16'd0);
        chk("awready_free", awready, 1'b1);
        chk("wready_free", wready, 1'b1);
    endtask

    task automatic rd(input logic [31:0] addr);
        logic [31:0] ed;
        logic [1:0]  er;
        model_read(addr, ed, er);
        araddr = addr; arvalid = 1;
        wait_rdy(3, "ar");
        @(posedge aclk); #1;
        arvalid = 0;
        chk("rvalid", rvalid, 1'b1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        chk("arready_busy", arready, 1'b0);
        rready = 1;
        @(posedge aclk); #1;
        rready = 0;
        chk("rvalid_clr", rvalid, 1'b0);
        chk("arready_free", arready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int idx;
        areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
`ifdef AXI_LITE_SLAVE_STATUS_EN
        sts = {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'hCAFE_0001};
`endif
        for (int k = 0; k < NR; k++) mreg[k] = '0;
        repeat (3) @(posedge aclk);
        #1 areset = 0;
        @(posedge aclk); #1;

        // Reset state
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pulse", pulse, 16'd0);
        chk("rst_cfg", cfg, '0);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);

        // Same-cycle AW+W to reg2
        wr(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("t1_reg2", cfg[2*32 +: 32], 32'hDEADBEEF);
        rd(32'h08);

        // W first with partial strobes, AW three cycles later
        wr(32'h0C, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        wr(32'h0C, 32'h11223344, 4'h5, 1, 3, 0);
        chk("t2_reg3", cfg[3*32 +: 32], 32'hAA22CC44);

        // Out-of-range write and read
        wr(32'h40, 32'h12345678, 4'hF, 2, 2, 0);
        rd(32'h40);

        // Back-pressure on B for five cycles, then immediate follow-on write
        wr(32'h10, 32'h0000A5A5, 4'h3, 0, 0, 5);
        wr(32'h14, 32'h5A5A0000, 4'hC, 0, 0, 0);

        // Zero strobe still responds OKAY and pulses
        wr(32'h18, 32'hFFFFFFFF, 4'h0, 0, 0, 0);

        // Read racing a commit to the same register sees the old value
        wr(32'h04, 32'h1, 4'hF, 0, 0, 0);
        awaddr = 32'h04; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h04;
        awvalid = 1; wvalid = 1; arvalid = 1;
        chk("t5_all_ready", {awready, wready, arready}, 3'b111);
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        mreg[1] = 32'h5;
        chk("t5_rvalid", rvalid, 1'b1);
        chk("t5_rdata_old", rdata, 32'h1);
        chk("t5_bvalid", bvalid, 1'b1);
        chk("t5_reg1_new", cfg[1*32 +: 32], 32'h5);
        bready = 1; rready = 1;
        @(posedge aclk); #1;
        bready = 0; rready = 0;
        rd(32'h04);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, NR + NS - 1);
            a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) < 2)
                wr(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 2));
            else
                rd(a);
        end

        // Reset with both responses pending
        awaddr = 32'h20; wdata = 32'h77; wstrb = 4'hF; araddr = 32'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t6_bvalid_pend", bvalid, 1'b1);
        chk("t6_rvalid_pend", rvalid, 1'b1);
        areset = 1;
        @(posedge aclk); #1;
        chk("t6_bvalid_rst", bvalid, 1'b0);
        chk("t6_rvalid_rst", rvalid, 1'b0);
        chk("t6_cfg_rst", cfg, '0);
        chk("t6_pulse_rst", pulse, 16'd0);
        areset = 0;
        for (int k = 0; k < NR; k++) mreg[k] = '0;
        @(posedge aclk); #1;
        chk("t6_awready_up", awready, 1'b1);
        rd(32'h08);
`ifdef AXI_LITE_SLAVE_STATUS_EN
        rd(32'h40);
        chk("t6_sts0", rdata, 32'hCAFE0001);
        wr(32'h44, 32'h1, 4'hF, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
